// File: rtl/auth_blk_if.sv
// auth_blk_if: BLE serial input, rider status and authorization outputs of auth_blk
interface auth_blk_if;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic       rx_rdy;
  logic [7:0] rx_data;
  modport master (output RX, rider_off, input pwr_up, rx_rdy, rx_data);
  modport slave  (input RX, rider_off, output pwr_up, rx_rdy, rx_data);
endinterface

// File: rtl/auth_blk.sv
// auth_blk: 8N1 UART receiver feeding a 3-state power authorization FSM (OFF/PWR1/PWR2)
module auth_blk #(
  parameter int         BAUD_DIV  = 2604,
  parameter logic [7:0] GO_CHAR   = 8'h67,
  parameter logic [7:0] STOP_CHAR = 8'h73
) (
  input  logic     clk,
  input  logic     rst_n,
  auth_blk_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_st_t;
  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_st_t;
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);
  // Reloading with BAUD_DIV-1 makes a 0-to-0 span exactly BAUD_DIV cycles, so no drift over 9 bits
  localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
  logic        rx_m_q, rx_s_q, rx_p_q;
  rx_st_t      rx_st_q, rx_st_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d, data_q, data_d;
  logic        rdy_q, rdy_d;
  auth_st_t    st_q, st_d;
  logic        expire, fall, go, stop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
      rx_st_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      st_q    <= OFF;
    end else begin
      rx_m_q  <= bus.RX;
      rx_s_q  <= rx_m_q;
      rx_p_q  <= rx_s_q;
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      st_q    <= st_d;
    end
  end
  assign expire = (cnt_q == 12'd0);
  assign fall   = rx_p_q & ~rx_s_q;
  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d   = expire ? FULL : cnt_q - 12'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    unique case (rx_st_q)
      IDLE: begin
        cnt_d   = HALF;
        rx_st_d = fall ? START : IDLE;
      end
      START: begin
        idx_d   = 3'd0;
        rx_st_d = !expire ? START : rx_s_q ? IDLE : DATA;
      end
      DATA: if (expire) begin
        sh_d    = {rx_s_q, sh_q[7:1]};
        idx_d   = idx_q + 3'd1;
        rx_st_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (expire) begin
        rdy_d   = rx_s_q;
        data_d  = rx_s_q ? sh_q : data_q;
        rx_st_d = IDLE;
      end
    endcase
  end
  assign go   = rdy_q && (data_q == GO_CHAR);
  assign stop = rdy_q && (data_q == STOP_CHAR);
  // GO outranks rider_off in PWR2 so a rider re-authorizing while stepping off stays powered
  always_comb begin
    st_d = (st_q == OFF)  ? (go ? PWR1 : OFF) :
           (st_q == PWR1) ? (stop ? (bus.rider_off ? OFF : PWR2) : PWR1) :
           (st_q == PWR2) ? (go ? PWR1 : bus.rider_off ? OFF : PWR2) : OFF;
  end
  assign bus.pwr_up  = (st_q != OFF);
  assign bus.rx_rdy  = rdy_q;
  assign bus.rx_data = data_q;
endmodule

// File: tb/tb_auth_blk.sv
// tb_auth_blk: directed bench for auth_blk at BAUD_DIV=16
module tb_auth_blk;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, rdy_n = 0, base = 0, gap = 0;
  int rdy_t [2] = '{0, 0};
  logic rdy_prev = 1'b0, pwr_post = 1'b0, pwr_at_rdy = 1'b0;
  auth_blk_if bus ();
  auth_blk #(.BAUD_DIV(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.rx_rdy) begin
      rdy_n++;
      rdy_t[1] = rdy_t[0];
      rdy_t[0] = cyc;
      pwr_at_rdy = bus.pwr_up;
    end
    if (rdy_prev) pwr_post = bus.pwr_up;
    rdy_prev = bus.rx_rdy;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic bit_tx(input logic v);
    bus.RX = v;
    idle(D);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    bit_tx(1'b0);
    for (int i = 0; i < 8; i++) bit_tx(b[i]);
    bit_tx(stop_b);
  endtask
  initial begin
    bus.RX = 1'b1;
    bus.rider_off = 1'b0;
    idle(3);
    chk("rst_pwr", bus.pwr_up, 0);
    chk("rst_rdy", bus.rx_rdy, 0);
    chk("rst_data", bus.rx_data, 8'h00);
    rst_n = 1'b1;
    idle(5);
    base = rdy_n;
    send_byte(8'h67, 1'b1);
    idle(4);
    chk("go_rdy_cnt", rdy_n - base, 1);
    chk("go_data", bus.rx_data, 8'h67);
    chk("go_pwr_at_rdy", pwr_at_rdy, 0);
    chk("go_pwr_next", pwr_post, 1);
    base = rdy_n;
    send_byte(8'h73, 1'b1);
    idle(4);
    chk("stop_on_rdy_cnt", rdy_n - base, 1);
    chk("stop_on_data", bus.rx_data, 8'h73);
    chk("stop_on_pwr", bus.pwr_up, 1);
    bus.rider_off = 1'b1;
    chk("off_pwr_before_edge", bus.pwr_up, 1);
    idle(1);
    chk("off_pwr_after_edge", bus.pwr_up, 0);
    send_byte(8'h67, 1'b1);
    idle(4);
    chk("go2_pwr", bus.pwr_up, 1);
    send_byte(8'h73, 1'b1);
    idle(4);
    chk("stop_off_pwr_at_rdy", pwr_at_rdy, 1);
    chk("stop_off_pwr_next", pwr_post, 0);
    base = rdy_n;
    send_byte(8'h41, 1'b1);
    idle(4);
    chk("other_rdy_cnt", rdy_n - base, 1);
    chk("other_data", bus.rx_data, 8'h41);
    chk("other_pwr", bus.pwr_up, 0);
    base = rdy_n;
    bus.RX = 1'b0;
    idle(5);
    bus.RX = 1'b1;
    idle(40);
    chk("glitch_rdy_cnt", rdy_n - base, 0);
    send_byte(8'h55, 1'b0);
    bus.RX = 1'b1;
    idle(40);
    chk("frame_rdy_cnt", rdy_n - base, 0);
    chk("frame_data", bus.rx_data, 8'h41);
    bus.rider_off = 1'b0;
    base = rdy_n;
    send_byte(8'h67, 1'b1);
    send_byte(8'h73, 1'b1);
    idle(4);
    gap = rdy_t[0] - rdy_t[1];
    chk("b2b_rdy_cnt", rdy_n - base, 2);
    chk("b2b_gap", (gap >= 158 && gap <= 162) ? 160 : gap, 160);
    chk("b2b_data", bus.rx_data, 8'h73);
    chk("b2b_pwr", bus.pwr_up, 1);
    bus.rider_off = 1'b1;
    idle(1);
    chk("b2b_pwr2_off", bus.pwr_up, 0);
    bus.rider_off = 1'b0;
    send_byte(8'h67, 1'b1);
    idle(4);
    chk("pre_rst_pwr", bus.pwr_up, 1);
    bit_tx(1'b0);
    for (int i = 0; i < 4; i++) bit_tx(i[0]);
    bus.RX = 1'b0;
    idle(8);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pwr", bus.pwr_up, 0);
    chk("midrst_rdy", bus.rx_rdy, 0);
    chk("midrst_data", bus.rx_data, 8'h00);
    bus.RX = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    base = rdy_n;
    send_byte(8'hA5, 1'b1);
    idle(4);
    chk("post_rst_rdy_cnt", rdy_n - base, 1);
    chk("post_rst_data", bus.rx_data, 8'hA5);
    chk("post_rst_pwr", bus.pwr_up, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/auth_blk.md
Name: auth_blk

Overview:
- Authorization front end of the Segway: receives 8N1 UART bytes from the BLE module on RX and decides whether the platform may be powered.
- Drives pwr_up, which gates balance_cntrl and steer_en downstream; nothing balances until pwr_up is high.
- Contains a self-contained UART receiver and a 3-state authorization FSM.
- Powers down only when a stop command has been received and the rider has stepped off.

Parameters:
- BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200 baud); legal range 8..4095.
- GO_CHAR, 8'h67, byte that authorizes power-up ('g').
- STOP_CHAR, 8'h73, byte that requests power-down ('s').

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset (synchronized deassertion supplied by rst_synch)
- RX  input  1  asynchronous UART serial in from BLE; idles high
- rider_off  input  1  high when steer_en reports no rider weight
- pwr_up  output  1  authorization to balance; high in any state other than OFF
- rx_rdy  output  1  one-cycle pulse when a valid byte is received
- rx_data  output  8  last valid byte received; held until the next valid byte

Behaviour:
- Reset (async, rst_n low): RX synchronizer flops = 1, UART FSM = IDLE, auth FSM = OFF, pwr_up = 0, rx_rdy = 0, rx_data = 8'h00. Reset mid-byte aborts reception with no rx_rdy.
- RX passes through 2 flops (rx_s) before any use. All UART timing below is relative to rx_s.
- UART FSM:
  - IDLE: on falling edge of rx_s (prev 1, now 0) -> START, load baud counter with BAUD_DIV/2 (integer divide).
  - START: at count 0, sample rx_s. If 0 -> DATA, bit index 0, counter = BAUD_DIV. If 1 (glitch) -> IDLE, no output.
  - DATA: at each counter expiry, shift rx_s in LSB first and reload the counter. After the 8th sample -> STOP.
  - STOP: at expiry, sample rx_s. If 1: rx_data <= shift register, rx_rdy = 1 for exactly one cycle, -> IDLE. If 0 (framing error): discard, no rx_rdy, -> IDLE. The FSM then waits for rx_s to return high before a new falling edge can be detected.
  - Counter is 12 bits; expiry means the count equals 0, then it reloads. One bit period = BAUD_DIV cycles ±1.
- Auth FSM (state changes only on a clk edge):
  - OFF: rx_rdy & rx_data==GO_CHAR -> PWR1. Any other byte is ignored.
  - PWR1: rx_rdy & rx_data==STOP_CHAR -> OFF if rider_off=1 in that cycle, else -> PWR2. rider_off alone has no effect.
  - PWR2: rider_off=1 -> OFF. If rx_rdy & rx_data==GO_CHAR in the same cycle as rider_off=1, GO wins -> PWR1. A GO byte without rider_off -> PWR1.
- pwr_up = (state != OFF), decoded directly from the state register, glitch-free. It rises on the clk edge after the rx_rdy cycle.
- Latency: the falling edge on the RX pin produces rx_rdy 2 (synchronizer) + BAUD_DIV/2 + 9*BAUD_DIV cycles later, ±2 cycles.
- Back-to-back bytes with zero idle time between the stop bit and the next start bit must be received without loss.

Test Plan:
- BAUD_DIV=16. Reset, then send 8'h67 -> rx_rdy pulses once with rx_data=8'h67, and pwr_up=1 on the next cycle.
- Powered, rider_off=0, send 8'h73 -> pwr_up stays 1. Then raise rider_off -> pwr_up=0 on the next clk edge.
- Powered, rider_off=1, send 8'h73 -> pwr_up=0 right after rx_rdy. Send 8'h41 -> no change, rx_data=8'h41.
- Drive a 5-cycle low glitch on RX -> no rx_rdy. Send a byte with stop bit forced 0 -> no rx_rdy and rx_data unchanged.
- Send 8'h67 then 8'h73 back-to-back with no idle bit (rider_off=0) -> two rx_rdy pulses, 160 ±2 cycles apart, ending in state PWR2.
- Assert rst_n low during data bit 4 -> all outputs return to reset values immediately. The next full byte is received correctly.
